seg7_frame_decoder: RTL and testbench

Receiver for the multiplexed 7-segment display interface (`segments[6:0]`, `anodos[7:0]`) driven by the hex display drivers. It watches the scanned anode/segment lines, waits for each digit to settle, and decodes each segment pattern back to a hex nibble. It assembles one nibble per digit into a frame word and presents complete frames on a valid/ready handshake. The block is used in self-checking benches and on-board loopback tests to recover the displayed value from the driver's pins.

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seg7_digit_settle.sv | 95 +++++++++
 rtl/seg7_frame_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment frame decoder: active-high segment
// constants ordered {g,f,e,d,c,b,a}, the settle FSM state type and the
// pattern-to-nibble decode helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seg7_dec_state_e;

    // Returns {valid, blank, nibble}; unknown patterns give valid=0, nibble 0.
    function automatic logic [5:0] seg7_decode(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            SEG_0:     res = {1'b1, 1'b0, 4'h0};
            SEG_1:     res = {1'b1, 1'b0, 4'h1};
            SEG_2:     res = {1'b1, 1'b0, 4'h2};
            SEG_3:     res = {1'b1, 1'b0, 4'h3};
            SEG_4:     res = {1'b1, 1'b0, 4'h4};
            SEG_5:     res = {1'b1, 1'b0, 4'h5};
            SEG_6:     res = {1'b1, 1'b0, 4'h6};
            SEG_7:     res = {1'b1, 1'b0, 4'h7};
            SEG_8:     res = {1'b1, 1'b0, 4'h8};
            SEG_9:     res = {1'b1, 1'b0, 4'h9};
            SEG_A:     res = {1'b1, 1'b0, 4'hA};
            SEG_B:     res = {1'b1, 1'b0, 4'hB};
            SEG_C:     res = {1'b1, 1'b0, 4'hC};
            SEG_D:     res = {1'b1, 1'b0, 4'hD};
            SEG_E:     res = {1'b1, 1'b0, 4'hE};
            SEG_F:     res = {1'b1, 1'b0, 4'hF};
            SEG_BLANK: res = {1'b1, 1'b1, 4'h0};
            default:   res = {1'b0, 1'b0, 4'h0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_digit_settle.sv
// Input register and per-dwell settle detector. The FSM judges each incoming
// sample against the value already held in seg_r/an_r, so a pin change is
// counted on the edge that registers it and a stable digit is captured
// SETTLE_CYCLES edges after it appears. Exactly one capture per anode dwell.
module seg7_digit_settle
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int ACTIVE_LOW    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          segments,
    input  logic [N_DIGITS-1:0] anodes,
    output logic                capture,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE_CYCLES);

    logic [6:0]          seg_in_s;
    logic [N_DIGITS-1:0] an_in_s;
    logic [6:0]          seg_r;
    logic [N_DIGITS-1:0] an_r;
    logic [3:0]          count_r;
    seg7_dec_state_e     state_r;
    logic                changed_s;
    logic                advance_s;
    logic [3:0]          next_count_s;

    assign seg_in_s  = (ACTIVE_LOW != 0) ? ~segments : segments;
    assign an_in_s   = (ACTIVE_LOW != 0) ? ~anodes : anodes;
    assign changed_s = ({seg_in_s, an_in_s} != {seg_r, an_r});

    // Decide whether this sample advances a dwell and what the count becomes.
    always_comb begin
        advance_s    = 1'b0;
        next_count_s = 4'd1;
        case (state_r)
            ST_IDLE: begin
                advance_s = (an_in_s != '0);
            end
            ST_SETTLE: begin
                advance_s = (an_in_s != '0);
                if (changed_s) begin
                    next_count_s = 4'd1;
                end else begin
                    next_count_s = count_r + 4'd1;
                end
            end
            ST_HOLD: begin
                advance_s = (an_in_s != '0) && changed_s;
            end
            default: begin
                advance_s = 1'b0;
            end
        endcase
    end

    // Input register, settle FSM and registered capture strobe/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r   <= 7'd0;
            an_r    <= '0;
            count_r <= 4'd0;
            state_r <= ST_IDLE;
            capture <= 1'b0;
            seg     <= 7'd0;
            an      <= '0;
        end else begin
            seg_r   <= seg_in_s;
            an_r    <= an_in_s;
            capture <= 1'b0;
            if (advance_s) begin
                count_r <= next_count_s;
                if (next_count_s >= SETTLE_C) begin
                    capture <= 1'b1;
                    seg     <= seg_in_s;
                    an      <= an_in_s;
                    state_r <= ST_HOLD;
                end else begin
                    state_r <= ST_SETTLE;
                end
            end else if ((an_in_s == '0) && ((state_r != ST_HOLD) || changed_s)) begin
                count_r <= 4'd0;
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Recovers hex frames from a multiplexed 7-segment bus. Captured digits fill
// a shadow frame; once every digit has been seen the frame is offered on a
// valid/ready handshake. Build option SEG7_DEC_ERR_COUNT_EN adds a saturating
// error-event counter on o_err_count (tied to 0 otherwise).
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int ACTIVE_LOW    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [6:0]            i_segments,
    input  logic [N_DIGITS-1:0]   i_anodos,
    input  logic                  i_ready,
    output logic [4*N_DIGITS-1:0] o_digits,
    output logic [N_DIGITS-1:0]   o_blank,
    output logic                  o_valid,
    output logic                  o_overrun,
    output logic                  o_err_pattern,
    output logic                  o_err_anode,
    output logic [7:0]            o_err_count
);

    logic                  cap_s;
    logic [6:0]            cap_seg_s;
    logic [N_DIGITS-1:0]   cap_an_s;
    logic [5:0]            dec_s;
    logic                  wr_s;
    logic                  pat_err_s;
    logic                  an_err_s;
    logic                  complete_s;
    logic                  ovr_event_s;
    logic [4*N_DIGITS-1:0] shadow_digits_r;
    logic [N_DIGITS-1:0]   shadow_blank_r;
    logic [N_DIGITS-1:0]   seen_r;
    logic [4*N_DIGITS-1:0] shadow_digits_n;
    logic [N_DIGITS-1:0]   shadow_blank_n;
    logic [N_DIGITS-1:0]   seen_n;

    seg7_digit_settle #(
        .N_DIGITS      (N_DIGITS),
        .ACTIVE_LOW    (ACTIVE_LOW),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk      (i_clk),
        .reset    (i_reset),
        .segments (i_segments),
        .anodes   (i_anodos),
        .capture  (cap_s),
        .seg      (cap_seg_s),
        .an       (cap_an_s)
    );

    assign dec_s       = seg7_decode(cap_seg_s);
    assign wr_s        = cap_s && $onehot(cap_an_s);
    assign an_err_s    = cap_s && !$onehot(cap_an_s);
    assign pat_err_s   = cap_s && !dec_s[5];
    assign complete_s  = wr_s && (seen_n == '1);
    assign ovr_event_s = complete_s && o_valid && !i_ready;

    // Next shadow frame: a one-hot capture writes its nibble and blank bit.
    always_comb begin
        shadow_digits_n = shadow_digits_r;
        shadow_blank_n  = shadow_blank_r;
        seen_n          = seen_r;
        if (wr_s) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (cap_an_s[k]) begin
                    shadow_digits_n[4*k +: 4] = dec_s[3:0];
                    shadow_blank_n[k]         = dec_s[4];
                    seen_n[k]                 = 1'b1;
                end else begin
                    seen_n[k] = seen_n[k];
                end
            end
        end else begin
            seen_n = seen_r;
        end
    end

    // Frame assembly, output handshake, overrun pulse and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shadow_digits_r <= '0;
            shadow_blank_r  <= '0;
            seen_r          <= '0;
            o_digits        <= '0;
            o_blank         <= '0;
            o_valid         <= 1'b0;
            o_overrun       <= 1'b0;
            o_err_pattern   <= 1'b0;
            o_err_anode     <= 1'b0;
        end else begin
            shadow_digits_r <= shadow_digits_n;
            shadow_blank_r  <= shadow_blank_n;
            o_overrun       <= ovr_event_s;
            if (complete_s) begin
                seen_r <= '0;
                if (!ovr_event_s) begin
                    o_digits <= shadow_digits_n;
                    o_blank  <= shadow_blank_n;
                    o_valid  <= 1'b1;
                end else begin
                    o_valid <= o_valid;
                end
            end else begin
                seen_r <= seen_n;
                if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end else begin
                    o_valid <= o_valid;
                end
            end
            if (pat_err_s) begin
                o_err_pattern <= 1'b1;
            end
            if (an_err_s) begin
                o_err_anode <= 1'b1;
            end
        end
    end

`ifdef SEG7_DEC_ERR_COUNT_EN
    logic [7:0] err_count_r;
    logic [1:0] err_inc_s;
    logic [8:0] err_sum_s;

    // A bad capture and an overrun can land on the same edge, hence a 2-bit step.
    assign err_inc_s = {1'b0, (pat_err_s || an_err_s)} + {1'b0, ovr_event_s};
    assign err_sum_s = {1'b0, err_count_r} + {7'd0, err_inc_s};

    // Saturating error-event counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_count_r <= 8'd0;
        end else if (err_sum_s[8]) begin
            err_count_r <= 8'hFF;
        end else begin
            err_count_r <= err_sum_s[7:0];
        end
    end

    assign o_err_count = err_count_r;
`else
    assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder (default parameters, active-low
// pins). Expected frames come from a small bench-side capture model and are
// queued when stimulus is driven; a monitor queues every accepted frame.
module tb_seg7_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        ready;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        valid;
    logic        overrun;
    logic        err_pat;
    logic        err_an;
    logic [7:0]  err_count;

`ifdef SEG7_DEC_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_frame_decoder dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_segments    (seg),
        .i_anodos      (an),
        .i_ready       (ready),
        .o_digits      (digits),
        .o_blank       (blank),
        .o_valid       (valid),
        .o_overrun     (overrun),
        .o_err_pattern (err_pat),
        .o_err_anode   (err_an),
        .o_err_count   (err_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    int          ovr_cnt      = 0;
    int          valid_cycles = 0;

    logic [3:0]  m_nib [8];
    logic [7:0]  m_blank;
    logic [7:0]  m_seen;
    logic        m_done;
    logic [39:0] m_frame;

    // Monitor: collect accepted frames, overrun pulses and valid-high cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) got_q.push_back({digits, blank});
            if (overrun) ovr_cnt = ovr_cnt + 1;
            if (valid) valid_cycles = valid_cycles + 1;
        end
    end

    task automatic drive(input logic [7:0] an_ah, input logic [6:0] seg_ah, input int dwell);
        an  = ~an_ah;
        seg = ~seg_ah;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(8'h00, 7'h00, n);
    endtask

    task automatic model_cap(input int k, input logic [3:0] nib, input logic bl);
        m_nib[k]  = nib;
        m_blank[k] = bl;
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_done = 1'b1;
            m_seen = 8'h00;
            m_frame[7:0] = m_blank;
            for (int i = 0; i < 8; i++) m_frame[8+4*i +: 4] = m_nib[i];
        end
    endtask

    task automatic digit(input int k, input logic [6:0] seg_ah, input logic [3:0] nib,
                         input logic bl, input int dwell, input bit push_ok);
        m_done = 1'b0;
        drive(8'(1 << k), seg_ah, dwell);
        if (dwell >= 2) model_cap(k, nib, bl);
        if (m_done && push_ok) exp_q.push_back(m_frame);
    endtask

    task automatic scan(input logic [31:0] word, input int dwell, input int short_k,
                        input int short_dwell, input bit push_ok);
        for (int k = 0; k < 8; k++) begin
            int d;
            d = (k == short_k) ? short_dwell : dwell;
            digit(k, PAT[word[4*k +: 4]], word[4*k +: 4], 1'b0, d, push_ok);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 8'hFF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_seen  = 8'h00;
        m_blank = 8'h00;
        m_done  = 1'b0;
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        ready = 1'b1;
        do_reset();
        n_checks++; if ({digits, blank} !== 40'd0) $display("FAIL reset_frame got=%h exp=0", {digits, blank}); else n_pass++;
        n_checks++; if ({valid, overrun, err_pat, err_an} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {valid, overrun, err_pat, err_an}); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else n_pass++;
    endtask

    task automatic test_frame_decode();
        int vbase;
        logic [39:0] e, g;
        ready = 1'b1;
        do_reset();
        vbase = valid_cycles;
        for (int k = 0; k < 7; k++) digit(k, PAT[k+1], 4'(k + 1), 1'b0, 4, 1'b1);
        an  = ~8'h80;
        seg = ~PAT[8];
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL decode_valid_early1 got=%b exp=0", valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL decode_valid_early2 got=%b exp=0", valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b1) $display("FAIL decode_valid_rise got=%b exp=1", valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL decode_valid_fall got=%b exp=0", valid); else n_pass++;
        m_done = 1'b0;
        model_cap(7, 4'h8, 1'b0);
        if (m_done) exp_q.push_back(m_frame);
        idle(4);
        n_checks++; if (exp_q.size() != 1 || exp_q[0] !== {32'h87654321, 8'h00}) $display("FAIL decode_model got=%0d exp=1", exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL decode_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL decode_frame got=%h exp=%h", g, e); else n_pass++;
        end
        n_checks++; if (valid_cycles - vbase != 1) $display("FAIL decode_valid_len got=%0d exp=1", valid_cycles - vbase); else n_pass++;
    endtask

    task automatic test_blank_error();
        logic [39:0] e, g;
        ready = 1'b1;
        do_reset();
        digit(0, PAT[9],  4'h9, 1'b0, 4, 1'b1);
        digit(1, PAT[10], 4'hA, 1'b0, 4, 1'b1);
        digit(2, 7'h00,   4'h0, 1'b1, 4, 1'b1);
        digit(3, PAT[12], 4'hC, 1'b0, 4, 1'b1);
        digit(4, PAT[13], 4'hD, 1'b0, 4, 1'b1);
        digit(5, 7'h01,   4'h0, 1'b0, 4, 1'b1);
        digit(6, PAT[15], 4'hF, 1'b0, 4, 1'b1);
        digit(7, PAT[1],  4'h1, 1'b0, 4, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL blank_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL blank_frame got=%h exp=%h", g, e); else n_pass++;
        end
        n_checks++; if (blank !== 8'h04) $display("FAIL blank_bits got=%h exp=04", blank); else n_pass++;
        n_checks++; if ({err_pat, err_an} !== 2'b10) $display("FAIL blank_err_flags got=%b exp=10", {err_pat, err_an}); else n_pass++;
        n_checks++; if (err_count !== (CNT_EN ? 8'd1 : 8'd0)) $display("FAIL blank_err_count got=%0d exp=%0d", err_count, CNT_EN ? 1 : 0); else n_pass++;
    endtask

    task automatic test_short_dwell();
        logic [39:0] e, g;
        ready = 1'b1;
        do_reset();
        scan(32'h13572468, 4, 3, 1, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 0) $display("FAIL short_no_frame got=%0d exp=0", got_q.size()); else n_pass++;
        scan(32'hFEDCBA98, 4, 3, 3, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != exp_q.size() || exp_q.size() != 1) $display("FAIL short_count got=%0d exp=1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== {32'h1357BA98, 8'h00}) $display("FAIL short_frame got=%h exp=%h", g, {32'h1357BA98, 8'h00}); else n_pass++;
            n_checks++; if (g !== e) $display("FAIL short_model got=%h exp=%h", g, e); else n_pass++;
        end
    endtask

    task automatic test_overrun();
        int obase;
        logic [39:0] e, g;
        ready = 1'b0;
        do_reset();
        obase = ovr_cnt;
        scan(32'h10FEDCBA, 4, 8, 4, 1'b1);
        scan(32'h76543210, 4, 8, 4, 1'b0);
        idle(4);
        n_checks++; if (ovr_cnt - obase != 1) $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - obase); else n_pass++;
        n_checks++; if ({valid, digits, blank} !== {1'b1, 32'h10FEDCBA, 8'h00}) $display("FAIL overrun_held got=%h exp=%h", {valid, digits, blank}, {1'b1, 32'h10FEDCBA, 8'h00}); else n_pass++;
        n_checks++; if (err_count !== (CNT_EN ? 8'd1 : 8'd0)) $display("FAIL overrun_err_count got=%0d exp=%0d", err_count, CNT_EN ? 1 : 0); else n_pass++;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL overrun_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL overrun_frame got=%h exp=%h", g, e); else n_pass++;
        end
        n_checks++; if (valid !== 1'b0) $display("FAIL overrun_valid_drop got=%b exp=0", valid); else n_pass++;
    endtask

    task automatic test_two_anodes();
        logic [39:0] e, g;
        ready = 1'b1;
        do_reset();
        for (int k = 0; k < 7; k++) digit(k, PAT[k+1], 4'(k + 1), 1'b0, 4, 1'b1);
        drive(8'h03, PAT[14], 3);
        idle(4);
        n_checks++; if (got_q.size() != 0) $display("FAIL anode_no_frame got=%0d exp=0", got_q.size()); else n_pass++;
        n_checks++; if ({err_an, err_pat} !== 2'b10) $display("FAIL anode_flags got=%b exp=10", {err_an, err_pat}); else n_pass++;
        digit(7, PAT[8], 4'h8, 1'b0, 4, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL anode_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== {32'h87654321, 8'h00}) $display("FAIL anode_frame got=%h exp=%h", g, {32'h87654321, 8'h00}); else n_pass++;
        end
        n_checks++; if (err_count !== (CNT_EN ? 8'd1 : 8'd0)) $display("FAIL anode_err_count got=%0d exp=%0d", err_count, CNT_EN ? 1 : 0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int vbase;
        logic [39:0] e, g;
        ready = 1'b0;
        do_reset();
        digit(0, 7'h01, 4'h0, 1'b0, 4, 1'b0);
        for (int k = 1; k < 8; k++) digit(k, PAT[k+8], 4'(k + 8), 1'b0, 4, 1'b0);
        for (int k = 0; k < 5; k++) digit(k, PAT[k+3], 4'(k + 3), 1'b0, 4, 1'b0);
        do_reset();
        n_checks++; if ({valid, digits, blank} !== 41'd0) $display("FAIL midreset_outputs got=%h exp=0", {valid, digits, blank}); else n_pass++;
        n_checks++; if ({err_pat, err_an, err_count} !== 10'd0) $display("FAIL midreset_errors got=%h exp=0", {err_pat, err_an, err_count}); else n_pass++;
        ready = 1'b1;
        vbase = valid_cycles;
        for (int k = 5; k < 8; k++) digit(k, PAT[k], 4'(k), 1'b0, 4, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 0) $display("FAIL midreset_seen_cleared got=%0d exp=0", got_q.size()); else n_pass++;
        for (int k = 0; k < 5; k++) digit(k, PAT[k+10], 4'(k + 10), 1'b0, 4, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 1 || exp_q.size() != 1) $display("FAIL midreset_count got=%0d exp=1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== {32'h765EDCBA, 8'h00}) $display("FAIL midreset_frame got=%h exp=%h", g, {32'h765EDCBA, 8'h00}); else n_pass++;
            n_checks++; if (g !== e) $display("FAIL midreset_model got=%h exp=%h", g, e); else n_pass++;
        end
        n_checks++; if (valid_cycles - vbase != 1) $display("FAIL midreset_valid_len got=%0d exp=1", valid_cycles - vbase); else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        an    = 8'hFF;
        seg   = 7'h7F;
        @(posedge clk);
        #1;
        test_reset();
        test_frame_decode();
        test_blank_error();
        test_short_dwell();
        test_overrun();
        test_two_anodes();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
